// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : shared FSM state codes, width defaults and ALU opcodes
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

   localparam int DEF_NB_DATA = 8;
   localparam int DEF_NB_OP   = 6;
   localparam int STATE_W     = 3;

   localparam logic [STATE_W-1:0] WAIT_A  = 3'd0;
   localparam logic [STATE_W-1:0] WAIT_B  = 3'd1;
   localparam logic [STATE_W-1:0] WAIT_OP = 3'd2;
   localparam logic [STATE_W-1:0] SEND    = 3'd3;
   localparam logic [STATE_W-1:0] WAIT_TX = 3'd4;

   localparam logic [5:0] ADD = 6'b100000;
   localparam logic [5:0] SUB = 6'b100010;
   localparam logic [5:0] AND = 6'b100100;
   localparam logic [5:0] OR  = 6'b100101;
   localparam logic [5:0] XOR = 6'b100110;
   localparam logic [5:0] NOR = 6'b100111;
   localparam logic [5:0] SRA = 6'b000011;
   localparam logic [5:0] SRL = 6'b000010;

endpackage

`default_nettype wire

// File: rtl/alu_if_timeout.sv
// ============================================================================
// alu_if_timeout : idle down-counter that flags an abandoned partial frame
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_if_timeout #(
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic count_en,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   logic [CNT_W-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (load)
         count_d = RELOAD;
      else if (count_en && (count_q != '0))
         count_d = count_q - ONE;
   end

   // Flag on the edge that takes the count to zero so the FSM leaves on that same edge.
   assign expired = count_en && !load && (count_q <= ONE);

   always_ff @(posedge clk) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

endmodule

`default_nettype wire

// File: rtl/alu_uart_interface.sv
// ============================================================================
// alu_uart_interface : collects A/B/opcode bytes from UART, sends ALU result
// Optional partial-frame timeout with ALU_IF_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module alu_uart_interface
   import alu_pkg::*;
#(
   parameter int NB_DATA        = DEF_NB_DATA,
   parameter int NB_OP          = DEF_NB_OP,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NB_DATA-1:0] rx_data,
   input  logic               rx_done,
   input  logic               tx_busy,
   input  logic               tx_done,
   input  logic [NB_DATA-1:0] alu_result,
   output logic [NB_DATA-1:0] alu_a,
   output logic [NB_DATA-1:0] alu_b,
   output logic [NB_OP-1:0]   alu_op,
   output logic [NB_DATA-1:0] tx_data,
   output logic               tx_start,
   output logic [2:0]         state
);

   logic [STATE_W-1:0] state_d, state_q;
   logic [NB_DATA-1:0] alu_a_d, alu_a_q;
   logic [NB_DATA-1:0] alu_b_d, alu_b_q;
   logic [NB_OP-1:0]   alu_op_d, alu_op_q;
   logic [NB_DATA-1:0] tx_data_d, tx_data_q;
   logic               tx_start_d, tx_start_q;
   logic               timeout_expired;

`ifdef ALU_IF_TIMEOUT_EN
   alu_if_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .load     (rx_done),
      .count_en ((state_q == WAIT_B) || (state_q == WAIT_OP)),
      .expired  (timeout_expired)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign timeout_expired    = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_op_d   = alu_op_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      case (state_q)
         WAIT_A: begin
            if (rx_done) begin
               alu_a_d = rx_data;
               state_d = WAIT_B;
            end
         end
         WAIT_B: begin
            if (rx_done) begin
               alu_b_d = rx_data;
               state_d = WAIT_OP;
            end else if (timeout_expired) begin
               state_d = WAIT_A;
            end
         end
         WAIT_OP: begin
            if (rx_done) begin
               alu_op_d = rx_data[NB_OP-1:0];
               state_d  = SEND;
            end else if (timeout_expired) begin
               state_d = WAIT_A;
            end
         end
         SEND: begin
            if (!tx_busy) begin
               tx_data_d  = alu_result;
               tx_start_d = 1'b1;
               state_d    = WAIT_TX;
            end
         end
         // Bytes arriving here are deliberately dropped; there is no buffering.
         WAIT_TX: begin
            if (tx_done)
               state_d = WAIT_A;
         end
         default: state_d = WAIT_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= WAIT_A;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_op_q   <= alu_op_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
      end
   end

   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign alu_op   = alu_op_q;
   assign tx_data  = tx_data_q;
   assign tx_start = tx_start_q;
   assign state    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_uart_interface.sv
// ============================================================================
// tb_alu_uart_interface : directed + random frames against a frame-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_uart_interface;

   localparam int S_WAIT_A = 0, S_WAIT_B = 1, S_WAIT_OP = 2, S_SEND = 3, S_WAIT_TX = 4;
   localparam int TMO = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       tx_busy;
   logic       tx_done;
   logic [7:0] alu_result;
   logic [7:0] alu_a, alu_b, tx_data;
   logic [5:0] alu_op;
   logic       tx_start;
   logic [2:0] state;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pulses = 0;

   // Frame-level model of the registers the DUT should be holding.
   logic [7:0] m_a = 8'h00, m_b = 8'h00, m_tx = 8'h00;
   logic [5:0] m_op = 6'h00;

   always #5 clk = ~clk;

   alu_uart_interface #(
      .NB_DATA        (8),
      .NB_OP          (6),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_done    (rx_done),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .alu_result (alu_result),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .state      (state)
   );

   function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
      logic signed [7:0] sa;
      sa = a;
      case (op)
         6'b100000: return a + b;
         6'b100010: return a - b;
         6'b100100: return a & b;
         6'b100101: return a | b;
         6'b100110: return a ^ b;
         6'b100111: return ~(a | b);
         6'b000011: return sa >>> b;
         6'b000010: return a >> b;
         default:   return 8'h00;
      endcase
   endfunction

   always_comb alu_result = alu_ref(alu_a, alu_b, alu_op);

   always @(negedge clk) if (tx_start) n_pulses++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      rx_data = 8'($urandom);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_tx = 8'h00;
   endtask

   // drop_mode: 0 = clean, 1 = stray byte during WAIT_TX, 2 = rx_done with tx_done
   task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input int busy, input int txwait, input int drop_mode);
      int p0;
      p0 = n_pulses;
      send_byte(a);
      m_a = a;
      check_eq("state_wait_b", state, S_WAIT_B);
      check_eq("alu_a", alu_a, m_a);
      send_byte(b);
      m_b = b;
      check_eq("state_wait_op", state, S_WAIT_OP);
      check_eq("alu_b", alu_b, m_b);
      tx_busy = (busy > 0);
      send_byte(op);
      m_op = op[5:0];
      check_eq("state_send", state, S_SEND);
      check_eq("alu_op", alu_op, m_op);
      check_eq("tx_start_early", tx_start, 0);
      repeat (busy) tick();
      if (busy > 0) check_eq("state_held_busy", state, S_SEND);
      tx_busy = 1'b0;
      tick();
      m_tx = alu_ref(m_a, m_b, m_op);
      check_eq("tx_start_pulse", tx_start, 1);
      check_eq("tx_data", tx_data, m_tx);
      tick();
      check_eq("tx_start_drop", tx_start, 0);
      check_eq("state_wait_tx", state, S_WAIT_TX);
      repeat (txwait) tick();
      if (drop_mode == 1) begin
         send_byte(8'h55);
         check_eq("state_after_drop", state, S_WAIT_TX);
      end
      tx_done = 1'b1;
      if (drop_mode == 2) begin
         rx_data = 8'h66;
         rx_done = 1'b1;
      end
      tick();
      tx_done = 1'b0;
      rx_done = 1'b0;
      check_eq("state_wait_a", state, S_WAIT_A);
      check_eq("alu_a_kept", alu_a, m_a);
      check_eq("tx_data_held", tx_data, m_tx);
      check_eq("pulse_count", n_pulses - p0, 1);
   endtask

   initial begin
      logic [5:0] ops [8];
      logic [7:0] opb;
      int p0;
      ops = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
              6'b100110, 6'b100111, 6'b000011, 6'b000010};
      reset = 1'b1; rx_data = 8'h00; rx_done = 1'b0; tx_busy = 1'b0; tx_done = 1'b0;
      tick(); tick();
      check_eq("rst_alu_a", alu_a, 0);
      check_eq("rst_alu_b", alu_b, 0);
      check_eq("rst_alu_op", alu_op, 0);
      check_eq("rst_tx_data", tx_data, 0);
      check_eq("rst_tx_start", tx_start, 0);
      check_eq("rst_state", state, S_WAIT_A);
      reset = 1'b0;
      tick();

      run_frame(8'h90, 8'h01, 8'h20, 0, 2, 0);
      check_eq("add_result", tx_data, 8'h91);
      run_frame(8'h90, 8'h01, 8'hE2, 0, 1, 0);
      check_eq("sub_masked_op", alu_op, 6'h22);
      check_eq("sub_result", tx_data, 8'h8F);
      run_frame(8'h90, 8'h01, 8'h24, 10, 0, 0);
      check_eq("and_result", tx_data, 8'h00);
      run_frame(8'h33, 8'h44, 8'h25, 0, 3, 1);
      run_frame(8'h10, 8'h0F, 8'h26, 0, 0, 0);
      check_eq("after_drop_a", alu_a, 8'h10);
      run_frame(8'h21, 8'h02, 8'h27, 1, 0, 2);

      // Reset mid-frame
      send_byte(8'h90);
      send_byte(8'h01);
      do_reset();
      check_eq("mid_rst_alu_a", alu_a, 0);
      check_eq("mid_rst_alu_b", alu_b, 0);
      check_eq("mid_rst_alu_op", alu_op, 0);
      check_eq("mid_rst_tx_data", tx_data, 0);
      check_eq("mid_rst_state", state, S_WAIT_A);
      run_frame(8'h03, 8'h04, 8'h20, 0, 0, 0);
      check_eq("post_rst_result", tx_data, 8'h07);

      for (int i = 0; i < 24; i++) begin
         opb = {2'($urandom), ops[$urandom_range(0, 7)]};
         run_frame(8'($urandom), 8'($urandom), opb, $urandom_range(0, 3),
                   $urandom_range(0, 4), $urandom_range(0, 2));
      end

`ifdef ALU_IF_TIMEOUT_EN
      do_reset();
      p0 = n_pulses;
      send_byte(8'h90);
      m_a = 8'h90;
      repeat (TMO - 1) tick();
      check_eq("tmo_not_yet", state, S_WAIT_B);
      tick();
      check_eq("tmo_expired", state, S_WAIT_A);
      check_eq("tmo_alu_a_kept", alu_a, 8'h90);
      repeat (3) tick();
      check_eq("tmo_no_tx", n_pulses - p0, 0);
      send_byte(8'h90);
      repeat (TMO - 1) tick();
      send_byte(8'h11);
      check_eq("tmo_race_state", state, S_WAIT_OP);
      check_eq("tmo_race_alu_b", alu_b, 8'h11);
      do_reset();
`else
      p0 = n_pulses;
      send_byte(8'h90);
      repeat (TMO + 8) tick();
      check_eq("no_tmo_wait_b", state, S_WAIT_B);
      check_eq("no_tmo_no_tx", n_pulses - p0, 0);
      do_reset();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_uart_interface.md
# alu_uart_interface

Sequential front-end for the 8-bit ALU. Receives operand A, operand B and the opcode as three consecutive bytes from the UART receiver and holds them on registered outputs that drive the ALU's A/B/Op inputs. Captures the ALU's combinational result and hands it to the UART transmitter with a start/done handshake. Sits between uart_rx/uart_tx and the ALU in the board top level.

## Interface
- NB_DATA, 8, operand/result width; also the UART byte width
- NB_OP, 6, opcode width; the low NB_OP bits of the opcode byte
- TIMEOUT_CYCLES, 50_000_000, idle cycles before a partial frame is discarded (only with ALU_IF_TIMEOUT_EN)
- clk  in  1  single system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- rx_data  in  NB_DATA  received byte; valid only while rx_done=1
- rx_done  in  1  one-cycle pulse per received byte
- tx_busy  in  1  transmitter busy
- tx_done  in  1  one-cycle pulse when the transmitted byte has finished
- alu_result  in  NB_DATA  combinational ALU output
- alu_a  out  NB_DATA  registered operand A to the ALU
- alu_b  out  NB_DATA  registered operand B to the ALU
- alu_op  out  NB_OP  registered opcode to the ALU
- tx_data  out  NB_DATA  registered result byte to the transmitter
- tx_start  out  1  one-cycle transmit request
- state  out  3  current FSM state, for LEDs

## Operation
- State encoding: WAIT_A=0, WAIT_B=1, WAIT_OP=2, SEND=3, WAIT_TX=4. All other codes go to WAIT_A.
- WAIT_A: on rx_done, alu_a <= rx_data and go to WAIT_B.
- WAIT_B: on rx_done, alu_b <= rx_data and go to WAIT_OP.
- WAIT_OP: on rx_done, alu_op <= rx_data[NB_OP-1:0] and go to SEND. Upper opcode bits are dropped without error.
- SEND: if tx_busy=0, then tx_data <= alu_result and tx_start <= 1, and go to WAIT_TX. If tx_busy=1, stay in SEND with tx_start=0.
- WAIT_TX: tx_start returns to 0. On tx_done, go to WAIT_A.
- rx_done in SEND or WAIT_TX is ignored and the byte is lost. The bench must not expect buffering.
- alu_a, alu_b and alu_op hold their values until overwritten. Starting a new frame does not clear them.
- Reset mid-frame at any state returns to WAIT_A and zeroes every register. Any frame in progress is abandoned.

## Timing
- Reset values: alu_a=0, alu_b=0, alu_op=0, tx_data=0, tx_start=0, state=WAIT_A (0).
- Opcode byte: rx_done sampled at edge N. alu_op and state=SEND are valid after edge N.
- Transmit: with tx_busy=0, tx_start=1 and tx_data are valid after edge N+1. That gives 2 cycles of latency from the opcode byte to tx_start.
- tx_start is high for exactly one cycle per frame.
- tx_data holds its value until the next SEND.
- tx_done sampled at edge M puts state=WAIT_A after edge M. The next rx_done at edge M+1 is accepted.
- rx_done and tx_done in the same cycle while in WAIT_TX: the FSM takes the tx_done transition and drops the rx byte.

## Configuration
- ALU_IF_TIMEOUT_EN defined:
  - A down-counter of width $clog2(TIMEOUT_CYCLES+1) reloads to TIMEOUT_CYCLES on entry to WAIT_B and WAIT_OP, and on every rx_done.
  - It decrements each cycle while the FSM is in WAIT_B or WAIT_OP.
  - When the count reaches 0, the FSM goes to WAIT_A. Registers keep their values and no byte is transmitted.
  - rx_done in the same cycle as the expiry wins: the byte is accepted.
- ALU_IF_TIMEOUT_EN undefined: no counter is built, and WAIT_B/WAIT_OP wait forever.

## Structure
- Shared package alu_pkg holds:
  - the state localparams (WAIT_A…WAIT_TX) and state width 3
  - NB_DATA/NB_OP defaults
  - opcode constants ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110, NOR=6'b100111, SRA=6'b000011, SRL=6'b000010
- One sub-module, alu_if_timeout (the counter), instantiated only under ALU_IF_TIMEOUT_EN. The FSM and registers stay in the top module.

## Test plan
- ADD: bytes 0x90, 0x01, 0x20 with a reference ALU attached -> alu_a=0x90, alu_b=0x01, alu_op=0x20; one tx_start pulse 2 cycles after the opcode byte, with tx_data=0x91.
- Opcode masking and SUB: bytes 0x90, 0x01, 0xE2 -> alu_op=0x22, tx_data=0x8F.
- Back-pressure: tx_busy=1 held for 10 cycles after the opcode byte (0x24 AND) -> tx_start stays low; it pulses exactly once, the cycle after tx_busy falls, with tx_data=0x00.
- Dropped byte: rx_done with 0x55 during WAIT_TX, then tx_done -> state=WAIT_A and alu_a unchanged; the next byte 0x10 loads alu_a=0x10.
- Reset mid-frame: bytes 0x90, 0x01, then reset for 1 cycle -> all outputs 0 and state=0 on the next cycle; a following full frame 0x03, 0x04, 0x20 gives tx_data=0x07.
- Timeout (ALU_IF_TIMEOUT_EN, TIMEOUT_CYCLES=16): byte 0x90, then silence -> state=WAIT_A after 16 cycles and no tx_start; a byte at exactly the expiry cycle is accepted instead.
